icache_responder: RTL and testbench

- Responder end of the fetch-to-instruction-cache request/grant interface. Serves instruction words to the fetch stage.
- Small direct-mapped instruction cache, one ILEN word per line, with tag/valid flop arrays.
- Hits return data combinationally in the request cycle. Misses run a single-outstanding refill FSM on a simple memory request/response bus.
- Sits between the fetch stage and the instruction memory / bus adapter.

---
 rtl/maverickOne_pkg.sv | 15 +
 rtl/icache_responder_if.sv | 31 +++
 rtl/icache_tag_array.sv | 47 ++++
 rtl/icache_responder.sv | 108 ++++++++++
 tb/tb_icache_responder.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/maverickOne_pkg.sv
// Shared core-wide constants and types for the maverickOne fetch path.
// Holds the instruction cache state encoding and its default geometry.
package maverickOne_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam int ICACHE_NUM_LINES = 64;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } icache_state_e;

endpackage

// File: rtl/icache_responder_if.sv
// Fetch request/grant handshake plus the refill memory bus of the instruction cache.
// The cache side uses the slave modport; the fetch stage / memory model uses master.
interface icache_responder_if
    import maverickOne_pkg::*;
#(
    parameter int XLEN = maverickOne_pkg::XLEN,
    parameter int ILEN = maverickOne_pkg::ILEN
);

    logic            req_i;
    logic [XLEN-1:0] addr_i;
    logic            gnt_o;
    logic [ILEN-1:0] data_o;
    logic            flush_i;

    logic            mem_req_o;
    logic [XLEN-1:0] mem_addr_o;
    logic            mem_rvalid_i;
    logic [ILEN-1:0] mem_rdata_i;

    modport slave (
        input  req_i, addr_i, flush_i, mem_rvalid_i, mem_rdata_i,
        output gnt_o, data_o, mem_req_o, mem_addr_o
    );

    modport master (
        output req_i, addr_i, flush_i, mem_rvalid_i, mem_rdata_i,
        input  gnt_o, data_o, mem_req_o, mem_addr_o
    );

endinterface

// File: rtl/icache_tag_array.sv
// Direct-mapped line storage: valid/tag/data flops with one combinational read
// port, one write port and a flash-invalidate of every valid bit.
module icache_tag_array #(
    parameter int NUM_LINES = 64,
    parameter int IDX_W     = 6,
    parameter int TAG_W     = 24,
    parameter int ILEN      = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inval_i,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [ILEN-1:0]  rd_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [ILEN-1:0]  wr_data,
    input  logic             wr_valid
);

    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [ILEN-1:0]      data_q [NUM_LINES];

    // Invalidate wins over a same-cycle write so a flushed fill never survives.
    always_ff @(posedge clk_i) begin
        if (rst_i || inval_i) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= wr_valid;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/icache_responder.sv
// Instruction cache responder: same-cycle hits, single-outstanding refill on miss,
// with a bypass grant in the refill data cycle and flush/drop handling.
module icache_responder
    import maverickOne_pkg::*;
#(
    parameter int XLEN      = maverickOne_pkg::XLEN,
    parameter int ILEN      = maverickOne_pkg::ILEN,
    parameter int NUM_LINES = ICACHE_NUM_LINES
) (
    input  logic              clk_i,
    input  logic              rst_i,
    icache_responder_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    localparam logic [0:0] ST_IDLE   = 1'(IDLE);
    localparam logic [0:0] ST_REFILL = 1'(REFILL);

    logic [0:0]      state_q;
    logic [XLEN-3:0] miss_word_q;
    logic            drop_q;

    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic [XLEN-3:0]  req_word;
    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [ILEN-1:0]  rd_data;
    logic             in_refill;
    logic             fill;
    logic             hit;
    logic             start_miss;
    logic             bypass;
    logic             unused_addr_lsb;

    assign req_word        = bus.addr_i[XLEN-1:2];
    assign req_idx         = bus.addr_i[IDX_W+1:2];
    assign req_tag         = bus.addr_i[XLEN-1:IDX_W+2];
    assign unused_addr_lsb = ^bus.addr_i[1:0];

    assign in_refill  = (state_q == ST_REFILL);
    assign fill       = in_refill && bus.mem_rvalid_i;
    assign hit        = bus.req_i && rd_valid && (rd_tag == req_tag) && !bus.flush_i;
    assign start_miss = !in_refill && bus.req_i && !hit && !bus.flush_i;
    // The refill word is forwarded only if the requester still wants that exact word.
    assign bypass     = fill && bus.req_i && !bus.flush_i && !drop_q &&
                        (req_word == miss_word_q);

    icache_tag_array #(
        .NUM_LINES (NUM_LINES),
        .IDX_W     (IDX_W),
        .TAG_W     (TAG_W),
        .ILEN      (ILEN)
    ) u_tag_array (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .inval_i  (bus.flush_i),
        .rd_idx   (req_idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (fill && !rst_i),
        .wr_idx   (miss_word_q[IDX_W-1:0]),
        .wr_tag   (miss_word_q[XLEN-3:IDX_W]),
        .wr_data  (bus.mem_rdata_i),
        .wr_valid (!(drop_q || bus.flush_i))
    );

    always_comb begin
        bus.gnt_o      = in_refill ? bypass : hit;
        bus.data_o     = fill ? bus.mem_rdata_i : rd_data;
        bus.mem_req_o  = in_refill;
        bus.mem_addr_o = in_refill ? {miss_word_q, 2'b00} : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            drop_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_miss) begin
                        state_q <= ST_REFILL;
                    end
                end
                ST_REFILL: begin
                    if (bus.mem_rvalid_i) begin
                        state_q <= ST_IDLE;
                        drop_q  <= 1'b0;
                    end else if (bus.flush_i) begin
                        drop_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (start_miss) begin
            miss_word_q <= req_word;
        end
    end

endmodule

// File: tb/tb_icache_responder.sv
// Bench for icache_responder: directed scenarios followed by random traffic
// checked against a line-level cache model.
module tb_icache_responder;
    import maverickOne_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    icache_responder_if bus ();

    icache_responder dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_i        = 1'b0;
        bus.addr_i       = '0;
        bus.flush_i      = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = '0;
    endtask

    // Drives a request that is known to miss and answers it in the first refill cycle.
    task automatic fill_line(input logic [31:0] a, input logic [31:0] d);
        bus.req_i = 1'b1; bus.addr_i = a;
        cyc();
        bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = d;
        cyc();
        bus.mem_rvalid_i = 1'b0; bus.req_i = 1'b0;
    endtask

    function automatic logic [31:0] memval(input logic [29:0] w);
        return ({w, 2'b00} * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        cyc(); cyc();
        #2;
        vectors++; if (bus.gnt_o !== 1'b0) begin miscompares++; $display("FAIL reset_gnt: got %0b want 0", bus.gnt_o); end
        vectors++; if (bus.mem_req_o !== 1'b0) begin miscompares++; $display("FAIL reset_mem_req: got %0b want 0", bus.mem_req_o); end
        vectors++; if (bus.mem_addr_o !== 32'h0) begin miscompares++; $display("FAIL reset_mem_addr: got %h want 0", bus.mem_addr_o); end
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_cold_miss();
        bus.req_i = 1'b1; bus.addr_i = 32'h1000;
        #2;
        vectors++; if (bus.gnt_o !== 1'b0) begin miscompares++; $display("FAIL cold_first_gnt: got %0b want 0", bus.gnt_o); end
        vectors++; if (bus.mem_req_o !== 1'b0) begin miscompares++; $display("FAIL cold_idle_mem_req: got %0b want 0", bus.mem_req_o); end
        cyc();
        for (int k = 0; k < 3; k++) begin
            if (k == 2) begin bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h0000_0013; end
            #2;
            vectors++; if (bus.mem_req_o !== 1'b1) begin miscompares++; $display("FAIL cold_mem_req[%0d]: got %0b want 1", k, bus.mem_req_o); end
            vectors++; if (bus.mem_addr_o !== 32'h1000) begin miscompares++; $display("FAIL cold_mem_addr[%0d]: got %h want 1000", k, bus.mem_addr_o); end
            vectors++; if (bus.gnt_o !== (k == 2)) begin miscompares++; $display("FAIL cold_gnt[%0d]: got %0b want %0b", k, bus.gnt_o, (k == 2)); end
            if (k == 2) begin
                vectors++; if (bus.data_o !== 32'h13) begin miscompares++; $display("FAIL cold_bypass_data: got %h want 00000013", bus.data_o); end
            end
            cyc();
        end
        bus.mem_rvalid_i = 1'b0;
        #2;
        vectors++; if (bus.gnt_o !== 1'b1) begin miscompares++; $display("FAIL cold_rehit_gnt: got %0b want 1", bus.gnt_o); end
        vectors++; if (bus.data_o !== 32'h13) begin miscompares++; $display("FAIL cold_rehit_data: got %h want 00000013", bus.data_o); end
        vectors++; if (bus.mem_req_o !== 1'b0) begin miscompares++; $display("FAIL cold_rehit_mem_req: got %0b want 0", bus.mem_req_o); end
        cyc();
        bus.req_i = 1'b0;
    endtask

    task automatic test_conflict();
        fill_line(32'h1100, 32'h0011_000A);
        bus.req_i = 1'b1; bus.addr_i = 32'h1100;
        #2;
        vectors++; if (bus.gnt_o !== 1'b1 || bus.data_o !== 32'h0011_000A) begin miscompares++; $display("FAIL conflict_new_hit: got gnt=%0b data=%h want gnt=1 data=0011000a", bus.gnt_o, bus.data_o); end
        cyc();
        bus.addr_i = 32'h1000;
        #2;
        vectors++; if (bus.gnt_o !== 1'b0) begin miscompares++; $display("FAIL conflict_evicted_gnt: got %0b want 0", bus.gnt_o); end
        cyc();
        #2;
        vectors++; if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'h1000) begin miscompares++; $display("FAIL conflict_refill: got req=%0b addr=%h want req=1 addr=1000", bus.mem_req_o, bus.mem_addr_o); end
        bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h13;
        cyc();
        bus.mem_rvalid_i = 1'b0; bus.req_i = 1'b0;
    endtask

    task automatic test_redirect();
        bus.req_i = 1'b1; bus.addr_i = 32'h2000;
        cyc();
        bus.addr_i = 32'h3000;
        #2;
        vectors++; if (bus.gnt_o !== 1'b0 || bus.mem_addr_o !== 32'h2000) begin miscompares++; $display("FAIL redir_wait: got gnt=%0b addr=%h want gnt=0 addr=2000", bus.gnt_o, bus.mem_addr_o); end
        cyc();
        bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h2222;
        #2;
        vectors++; if (bus.gnt_o !== 1'b0) begin miscompares++; $display("FAIL redir_no_bypass: got %0b want 0", bus.gnt_o); end
        cyc();
        bus.mem_rvalid_i = 1'b0; bus.addr_i = 32'h2000;
        #2;
        vectors++; if (bus.gnt_o !== 1'b1 || bus.data_o !== 32'h2222) begin miscompares++; $display("FAIL redir_filled: got gnt=%0b data=%h want gnt=1 data=00002222", bus.gnt_o, bus.data_o); end
        cyc();
        bus.addr_i = 32'h3000;
        #2;
        vectors++; if (bus.gnt_o !== 1'b0 || bus.mem_req_o !== 1'b0) begin miscompares++; $display("FAIL redir_new_miss: got gnt=%0b req=%0b want 0 0", bus.gnt_o, bus.mem_req_o); end
        cyc();
        #2;
        vectors++; if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'h3000) begin miscompares++; $display("FAIL redir_new_refill: got req=%0b addr=%h want req=1 addr=3000", bus.mem_req_o, bus.mem_addr_o); end
        bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h3333;
        #2;
        vectors++; if (bus.gnt_o !== 1'b1 || bus.data_o !== 32'h3333) begin miscompares++; $display("FAIL redir_bypass: got gnt=%0b data=%h want gnt=1 data=00003333", bus.gnt_o, bus.data_o); end
        cyc();
        bus.mem_rvalid_i = 1'b0; bus.req_i = 1'b0;
    endtask

    task automatic test_flush();
        bus.req_i = 1'b1; bus.addr_i = 32'h4000;
        cyc();
        bus.flush_i = 1'b1;
        #2;
        vectors++; if (bus.gnt_o !== 1'b0 || bus.mem_req_o !== 1'b1) begin miscompares++; $display("FAIL flush_refill_cycle: got gnt=%0b req=%0b want 0 1", bus.gnt_o, bus.mem_req_o); end
        cyc();
        bus.flush_i = 1'b0; bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h4444;
        #2;
        vectors++; if (bus.gnt_o !== 1'b0) begin miscompares++; $display("FAIL flush_drop_no_bypass: got %0b want 0", bus.gnt_o); end
        cyc();
        bus.mem_rvalid_i = 1'b0;
        #2;
        vectors++; if (bus.gnt_o !== 1'b0) begin miscompares++; $display("FAIL flush_fill_invalid: got %0b want 0", bus.gnt_o); end
        cyc();
        #2;
        vectors++; if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'h4000) begin miscompares++; $display("FAIL flush_rerefill: got req=%0b addr=%h want req=1 addr=4000", bus.mem_req_o, bus.mem_addr_o); end
        bus.mem_rvalid_i = 1'b1;
        cyc();
        bus.mem_rvalid_i = 1'b0;
        #2;
        vectors++; if (bus.gnt_o !== 1'b1 || bus.data_o !== 32'h4444) begin miscompares++; $display("FAIL flush_rehit: got gnt=%0b data=%h want gnt=1 data=00004444", bus.gnt_o, bus.data_o); end
        bus.flush_i = 1'b1;
        #2;
        vectors++; if (bus.gnt_o !== 1'b0) begin miscompares++; $display("FAIL flush_idle_gnt: got %0b want 0", bus.gnt_o); end
        cyc();
        bus.flush_i = 1'b0;
        #2;
        vectors++; if (bus.gnt_o !== 1'b0 || bus.mem_req_o !== 1'b0) begin miscompares++; $display("FAIL flush_idle_invalidated: got gnt=%0b req=%0b want 0 0", bus.gnt_o, bus.mem_req_o); end
        cyc();
        // Now refilling 0x4000; assert flush together with the fill.
        bus.flush_i = 1'b1; bus.mem_rvalid_i = 1'b1;
        #2;
        vectors++; if (bus.gnt_o !== 1'b0) begin miscompares++; $display("FAIL flush_with_fill_gnt: got %0b want 0", bus.gnt_o); end
        cyc();
        bus.flush_i = 1'b0; bus.mem_rvalid_i = 1'b0; bus.req_i = 1'b0;
        cyc();
        bus.req_i = 1'b1; bus.addr_i = 32'h4000;
        #2;
        vectors++; if (bus.gnt_o !== 1'b0) begin miscompares++; $display("FAIL flush_with_fill_invalid: got %0b want 0", bus.gnt_o); end
        bus.addr_i = 32'h7000; bus.flush_i = 1'b1;
        cyc();
        bus.flush_i = 1'b0; bus.req_i = 1'b0;
        #2;
        vectors++; if (bus.mem_req_o !== 1'b0) begin miscompares++; $display("FAIL flush_miss_no_refill: got %0b want 0", bus.mem_req_o); end
        cyc();
    endtask

    task automatic test_reset_mid_refill();
        bus.req_i = 1'b1; bus.addr_i = 32'h6000;
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0; bus.req_i = 1'b0;
        #2;
        vectors++; if (bus.mem_req_o !== 1'b0 || bus.gnt_o !== 1'b0 || bus.mem_addr_o !== 32'h0) begin miscompares++; $display("FAIL rstmid_abandon: got req=%0b gnt=%0b addr=%h want 0 0 0", bus.mem_req_o, bus.gnt_o, bus.mem_addr_o); end
        bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h6666;
        cyc();
        bus.mem_rvalid_i = 1'b0; bus.req_i = 1'b1;
        #2;
        vectors++; if (bus.gnt_o !== 1'b0 || bus.mem_req_o !== 1'b0) begin miscompares++; $display("FAIL rstmid_late_ignored: got gnt=%0b req=%0b want 0 0", bus.gnt_o, bus.mem_req_o); end
        cyc();
        #2;
        vectors++; if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'h6000) begin miscompares++; $display("FAIL rstmid_new_refill: got req=%0b addr=%h want req=1 addr=6000", bus.mem_req_o, bus.mem_addr_o); end
        bus.mem_rvalid_i = 1'b1;
        cyc();
        bus.mem_rvalid_i = 1'b0; bus.req_i = 1'b0;
        cyc();
    endtask

    task automatic test_low_bits();
        fill_line(32'h1000, 32'h13);
        bus.req_i = 1'b1; bus.addr_i = 32'h1002;
        #2;
        vectors++; if (bus.gnt_o !== 1'b1 || bus.data_o !== 32'h13) begin miscompares++; $display("FAIL lowbits_hit: got gnt=%0b data=%h want gnt=1 data=00000013", bus.gnt_o, bus.data_o); end
        cyc();
        bus.addr_i = 32'h5003;
        cyc();
        #2;
        vectors++; if (bus.mem_addr_o !== 32'h5000) begin miscompares++; $display("FAIL lowbits_mem_addr: got %h want 00005000", bus.mem_addr_o); end
        bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h5555;
        #2;
        vectors++; if (bus.gnt_o !== 1'b1 || bus.data_o !== 32'h5555) begin miscompares++; $display("FAIL lowbits_bypass: got gnt=%0b data=%h want gnt=1 data=00005555", bus.gnt_o, bus.data_o); end
        cyc();
        bus.mem_rvalid_i = 1'b0; bus.req_i = 1'b0;
        cyc();
    endtask

    task automatic test_random();
        bit          mv [64];
        logic [29:0] mw [64];
        logic [31:0] md [64];
        bit          busy, drop, e_hit, e_gnt, e_mreq;
        logic [29:0] pend, w;
        logic [31:0] e_data, e_maddr;
        int          cd;
        idle_inputs();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int j = 0; j < 64; j++) mv[j] = 1'b0;
        busy = 1'b0; drop = 1'b0; pend = '0; cd = 0;
        for (int n = 0; n < 600; n++) begin
            bus.req_i   = ($urandom_range(0, 3) != 0);
            bus.addr_i  = 32'h8000_0000 | (32'($urandom_range(0, 3)) << 8) |
                          (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            bus.flush_i = ($urandom_range(0, 15) == 0);
            bus.mem_rdata_i = $urandom;
            if (busy && cd == 0) begin
                bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = memval(pend);
            end else begin
                bus.mem_rvalid_i = (!busy && $urandom_range(0, 7) == 0);
            end
            w = bus.addr_i[31:2];
            if (!busy) begin
                e_hit   = bus.req_i && !bus.flush_i && mv[w[5:0]] && (mw[w[5:0]] == w);
                e_gnt   = e_hit;
                e_data  = md[w[5:0]];
                e_mreq  = 1'b0;
                e_maddr = 32'h0;
            end else begin
                e_hit   = 1'b0;
                e_gnt   = bus.mem_rvalid_i && bus.req_i && !bus.flush_i && !drop && (w == pend);
                e_data  = memval(pend);
                e_mreq  = 1'b1;
                e_maddr = {pend, 2'b00};
            end
            #2;
            vectors++; if (bus.gnt_o !== e_gnt) begin miscompares++; $display("FAIL rand_gnt[%0d]: got %0b want %0b", n, bus.gnt_o, e_gnt); end
            vectors++; if (bus.mem_req_o !== e_mreq) begin miscompares++; $display("FAIL rand_mem_req[%0d]: got %0b want %0b", n, bus.mem_req_o, e_mreq); end
            vectors++; if (bus.mem_addr_o !== e_maddr) begin miscompares++; $display("FAIL rand_mem_addr[%0d]: got %h want %h", n, bus.mem_addr_o, e_maddr); end
            if (e_gnt) begin
                vectors++; if (bus.data_o !== e_data) begin miscompares++; $display("FAIL rand_data[%0d]: got %h want %h", n, bus.data_o, e_data); end
            end
            if (bus.flush_i) for (int j = 0; j < 64; j++) mv[j] = 1'b0;
            if (!busy) begin
                if (bus.req_i && !e_hit && !bus.flush_i) begin
                    busy = 1'b1; pend = w; drop = 1'b0; cd = $urandom_range(0, 3);
                end
            end else if (bus.mem_rvalid_i) begin
                mw[pend[5:0]] = pend;
                md[pend[5:0]] = memval(pend);
                mv[pend[5:0]] = !(drop || bus.flush_i);
                busy = 1'b0; drop = 1'b0;
            end else begin
                if (bus.flush_i) drop = 1'b1;
                cd--;
            end
            cyc();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        #1;
        test_reset();
        test_cold_miss();
        test_conflict();
        test_redirect();
        test_flush();
        test_reset_mid_refill();
        test_low_bits();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
